// File: rtl/seg_disp_pkg.sv
// Shared encodings and the leading-zero blank helper for the 7-segment scan controller.
package seg_disp_pkg;

  localparam int DIGITS = 8;
  localparam int WORD_W = DIGITS * 4;

  typedef enum logic [1:0] {
    SRC_CPU = 2'd0,
    SRC_KBD = 2'd1,
    SRC_CNT = 2'd2
  } src_e;

  typedef enum logic [1:0] {
    MODE_AUTO = 2'd0,
    MODE_CPU  = 2'd1,
    MODE_KBD  = 2'd2,
    MODE_CNT  = 2'd3
  } mode_e;

  // Digits from the top stay blanked while every nibble seen so far is zero; digit 0 always shows.
  function automatic logic [DIGITS-1:0] lz_blank_mask(input logic [WORD_W-1:0] word);
    logic zero_run;
    lz_blank_mask = '0;
    zero_run      = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_run         = zero_run & (word[i*4 +: 4] == 4'd0);
      lz_blank_mask[i] = zero_run;
    end
  endfunction

endpackage

// File: rtl/sync_rise.sv
// Two-flop synchronizer for a slow level from another clock domain, followed by a
// registered one-cycle pulse on its rising edge.
module sync_rise (
  input  logic led_clk,
  input  logic rst,
  input  logic din_i,
  output logic rise_o
);

  logic meta_q, sync_q, prev_q, rise_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge led_clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= din_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/seg_display_scheduler.sv
// Scan controller and source arbiter for the 8-digit 7-segment display: one tear-free
// source snapshot per frame, PWM-dimmed anode scan and leading-zero blanking.
module seg_display_scheduler
  import seg_disp_pkg::*;
#(
  parameter int HOLD_FRAMES = 64,
  parameter int PHASES      = 8
) (
  input  logic              led_clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] cpu_data,
  input  logic [WORD_W-1:0] kbd_data,
  input  logic [WORD_W-1:0] cnt_data,
  input  logic              kbd_req,
  input  logic [1:0]        mode_sel,
  input  logic [2:0]        brightness,
  input  logic              blank_lz,
  output logic [DIGITS-1:0] AN,
  output logic [3:0]        digit,
  output logic              frame_start,
  output logic [1:0]        active_src
);

  localparam int            PW         = $clog2(PHASES);
  localparam logic [PW-1:0] PHASE_LAST = PW'(PHASES - 1);
  localparam logic [2:0]    IDX_LAST   = 3'(DIGITS - 1);
  localparam logic [7:0]    HOLD_INIT  = 8'(HOLD_FRAMES);

  logic [2:0]        idx_q, idx_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic [WORD_W-1:0] snapshot_q, snapshot_d;
  logic [2:0]        bright_q, bright_d;
  logic              blank_en_q, blank_en_d;
  logic [7:0]        hold_q, hold_d;
  src_e              src_q, src_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [3:0]        digit_q, digit_d;
  logic              fs_q, fs_d;

  src_e              sel_src;
  logic              kbd_rise;
  logic              frame_end;
  logic [7:0]        hold_arm;
  logic [DIGITS-1:0] blank_mask;
  logic              lit;

  sync_rise u_kbd_sync (
    .led_clk (led_clk),
    .rst     (rst),
    .din_i   (kbd_req),
    .rise_o  (kbd_rise)
  );

  assign frame_end = (idx_q == IDX_LAST) && (phase_q == PHASE_LAST);
  // A fresh keyboard edge re-arms the hold before this cycle's frame load can see it.
  assign hold_arm  = kbd_rise ? HOLD_INIT : hold_q;

  always_comb begin
    sel_src = SRC_CPU;
    unique case (mode_e'(mode_sel))
      MODE_CPU: sel_src = SRC_CPU;
      MODE_KBD: sel_src = SRC_KBD;
      MODE_CNT: sel_src = SRC_CNT;
      default:  sel_src = (hold_arm != 8'd0) ? SRC_KBD : SRC_CPU;
    endcase
  end

  always_comb begin
    // NOTE: every signal written here gets its default first, so no path can infer a latch.
    idx_d      = idx_q;
    phase_d    = phase_q + PW'(1);
    snapshot_d = snapshot_q;
    bright_d   = bright_q;
    blank_en_d = blank_en_q;
    src_d      = src_q;
    hold_d     = hold_arm;

    if (phase_q == PHASE_LAST) idx_d = idx_q + 3'd1;

    if (frame_end) begin
      src_d = sel_src;
      unique case (sel_src)
        SRC_KBD: snapshot_d = kbd_data;
        SRC_CNT: snapshot_d = cnt_data;
        default: snapshot_d = cpu_data;
      endcase
      bright_d   = brightness;
      blank_en_d = blank_lz;
      hold_d     = (hold_arm != 8'd0) ? hold_arm - 8'd1 : 8'd0;
    end

    // Outputs are derived from next state so the registered values match idx/phase after the edge.
    digit_d    = snapshot_d[{idx_d, 2'b00} +: 4];
    blank_mask = blank_en_d ? lz_blank_mask(snapshot_d) : '0;
    lit        = (int'(phase_d) <= int'(bright_d)) && !blank_mask[idx_d];
    an_d       = lit ? ~(DIGITS'(1) << idx_d) : '1;
    fs_d       = frame_end;
  end

  always_ff @(posedge led_clk) begin
    if (rst) begin
      idx_q      <= IDX_LAST;
      phase_q    <= PHASE_LAST;
      snapshot_q <= '0;
      bright_q   <= '0;
      blank_en_q <= 1'b0;
      hold_q     <= '0;
      src_q      <= SRC_CPU;
      an_q       <= '1;
      digit_q    <= '0;
      fs_q       <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      phase_q    <= phase_d;
      snapshot_q <= snapshot_d;
      bright_q   <= bright_d;
      blank_en_q <= blank_en_d;
      hold_q     <= hold_d;
      src_q      <= src_d;
      an_q       <= an_d;
      digit_q    <= digit_d;
      fs_q       <= fs_d;
    end
  end

  assign AN          = an_q;
  assign digit       = digit_q;
  assign frame_start = fs_q;
  assign active_src  = src_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed bench for seg_display_scheduler: a cycle model pushes expected outputs into a
// scoreboard before each edge, and they are popped and compared after the edge.
module tb_seg_display_scheduler;

  localparam int HOLD = 4;

  logic        led_clk;
  logic        rst;
  logic [31:0] cpu_data, kbd_data, cnt_data;
  logic        kbd_req;
  logic [1:0]  mode_sel;
  logic [2:0]  brightness;
  logic        blank_lz;
  logic [7:0]  AN;
  logic [3:0]  digit;
  logic        frame_start;
  logic [1:0]  active_src;

  seg_display_scheduler #(.HOLD_FRAMES(HOLD), .PHASES(8)) dut (
    .led_clk     (led_clk),
    .rst         (rst),
    .cpu_data    (cpu_data),
    .kbd_data    (kbd_data),
    .cnt_data    (cnt_data),
    .kbd_req     (kbd_req),
    .mode_sel    (mode_sel),
    .brightness  (brightness),
    .blank_lz    (blank_lz),
    .AN          (AN),
    .digit       (digit),
    .frame_start (frame_start),
    .active_src  (active_src)
  );

  initial begin
    led_clk = 1'b0;
    forever #5 led_clk = ~led_clk;
  end

  typedef struct packed {
    logic [7:0] an;
    logic [3:0] digit;
    logic       fs;
    logic [1:0] src;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   kbd_frames = 0;

  // Model state: position inside the 64-tick frame and the values latched at frame load.
  int          m_pos = 63;
  logic [31:0] m_word = '0;
  int          m_bright = 0;
  logic        m_blank = 1'b0;
  int          m_hold = 0;
  logic [1:0]  m_src = 2'd0;
  logic        m_fs = 1'b0;
  logic [3:0]  kh = '0;  // kh[k] = kbd_req sampled k+1 edges ago

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(output exp_t e);
    logic kedge;
    int   hold_e, idx, ph, top;
    logic lit;
    if (rst) begin
      m_pos = 63; m_word = '0; m_bright = 0; m_blank = 1'b0;
      m_hold = 0; m_src = 2'd0; m_fs = 1'b0; kh = '0;
    end else begin
      kedge = kh[2] & ~kh[3];
      kh    = {kh[2:0], kbd_req};
      if (m_pos == 63) begin
        hold_e = kedge ? HOLD : m_hold;
        case (mode_sel)
          2'd1:    m_src = 2'd0;
          2'd2:    m_src = 2'd1;
          2'd3:    m_src = 2'd2;
          default: m_src = (hold_e > 0) ? 2'd1 : 2'd0;
        endcase
        m_word   = (m_src == 2'd0) ? cpu_data : (m_src == 2'd1) ? kbd_data : cnt_data;
        m_hold   = (hold_e > 0) ? hold_e - 1 : 0;
        m_bright = int'(brightness);
        m_blank  = blank_lz;
      end else if (kedge) begin
        m_hold = HOLD;
      end
      m_pos = (m_pos + 1) % 64;
      m_fs  = (m_pos == 0);
    end
    idx = m_pos / 8;
    ph  = m_pos % 8;
    top = 0;
    for (int i = 0; i < 8; i++) if (m_word[i*4 +: 4] != 4'd0) top = i;
    lit     = (ph <= m_bright) && !(m_blank && idx > top);
    e.an    = lit ? ~(8'(1) << idx) : 8'hFF;
    e.digit = m_word[idx*4 +: 4];
    e.fs    = m_fs;
    e.src   = m_src;
  endtask

  task automatic step();
    exp_t e;
    model_edge(e);
    sb.push_back(e);
    @(posedge led_clk);
    #1;
    e = sb.pop_front();
    check("scan", {17'd0, AN, digit, frame_start, active_src}, {17'd0, e});
    if (frame_start === 1'b1 && active_src === 2'd1) kbd_frames++;
  endtask

  task automatic run_to_pos(input int p);
    int guard = 0;
    step();
    while (m_pos != p && guard < 64) begin
      step();
      guard++;
    end
    check("run_to_pos_bound", 32'(m_pos), 32'(p));
  endtask

  task automatic run_steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1; kbd_req = 1'b0; mode_sel = 2'd0; brightness = 3'd7; blank_lz = 1'b0;
    cpu_data = 32'h12345678; kbd_data = 32'h00C0FFEE; cnt_data = 32'h87654321;
    #1;
    run_steps(3);
    check("reset_an", 32'(AN), 32'hFF);

    // Test 1: full-brightness scan of the CPU word
    rst = 1'b0;
    step();
    check("first_frame_start", 32'(frame_start), 32'd1);
    check("first_an", 32'(AN), 32'hFE);
    check("first_digit", 32'(digit), 32'h8);
    run_to_pos(63);

    // Test 2: brightness 2, then a mid-frame change that waits for the next load
    brightness = 3'd2;
    run_to_pos(20);
    brightness = 3'd5;
    run_to_pos(27);
    check("bright_mid_frame_held", 32'(AN), 32'hFF);
    run_to_pos(0);
    run_to_pos(27);
    check("bright_after_load", 32'(AN), 32'hF7);

    // Test 3: leading-zero blanking
    blank_lz = 1'b1; cpu_data = 32'h00000A05;
    run_to_pos(0);
    run_to_pos(56);
    check("lz_top_blank", 32'(AN), 32'hFF);
    run_to_pos(16);
    check("lz_idx2_an", 32'(AN), 32'hFB);
    check("lz_idx2_digit", 32'(digit), 32'hA);
    cpu_data = 32'h0;
    run_to_pos(0);
    check("lz_zero_an", 32'(AN), 32'hFE);
    check("lz_zero_digit", 32'(digit), 32'h0);
    run_to_pos(8);
    check("lz_zero_idx1", 32'(AN), 32'hFF);

    // Test 4: keyboard hold for HOLD frames, then re-arm during the third KBD frame
    blank_lz = 1'b0; brightness = 3'd7; cpu_data = 32'h12345678;
    run_to_pos(10);
    kbd_req = 1'b1; run_steps(3); kbd_req = 1'b0;
    kbd_frames = 0;
    run_steps(6 * 64);
    check("kbd_hold_frames", 32'(kbd_frames), 32'd4);
    check("kbd_hold_expired", 32'(active_src), 32'd0);
    kbd_req = 1'b1; run_steps(3); kbd_req = 1'b0;
    kbd_frames = 0;
    run_steps(3 * 64);
    kbd_req = 1'b1; run_steps(3); kbd_req = 1'b0;
    run_steps(6 * 64);
    check("kbd_rearm_frames", 32'(kbd_frames), 32'd7);
    check("kbd_rearm_expired", 32'(active_src), 32'd0);

    // Test 5: edge landing on the load edge, then force/unforce
    run_to_pos(60);
    kbd_req = 1'b1;
    run_steps(3);
    kbd_req = 1'b0;
    step();
    check("edge_on_load_fs", 32'(frame_start), 32'd1);
    check("edge_on_load_src", 32'(active_src), 32'd1);
    mode_sel = 2'd3;
    run_to_pos(0);
    check("force_cnt_src", 32'(active_src), 32'd2);
    check("force_cnt_digit", 32'(digit), 32'h1);
    mode_sel = 2'd0;
    run_to_pos(0);
    check("resume_kbd_src", 32'(active_src), 32'd1);

    // Test 6: reset mid-frame at idx 4, phase 3
    run_to_pos(35);
    rst = 1'b1; cpu_data = 32'h9ABCDEF0;
    step();
    check("mid_reset_an0", 32'(AN), 32'hFF);
    step();
    check("mid_reset_an1", 32'(AN), 32'hFF);
    rst = 1'b0;
    step();
    check("post_reset_fs", 32'(frame_start), 32'd1);
    check("post_reset_src", 32'(active_src), 32'd0);
    check("post_reset_digit", 32'(digit), 32'h0);
    run_to_pos(8);
    check("post_reset_idx1_digit", 32'(digit), 32'hF);
    run_to_pos(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
